cram_dram_sched: RTL

//  Sequences the cartridge DRAM (RAS/CAS/WE, multiplexed row/column address) and

---
 rtl/cram_dram_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cram_dram_sched.sv
// Cartridge DRAM access engine: arbitrates the C64 bus port and an auxiliary
// port onto one DRAM, sequences RAS/CAS/WE and schedules CBR refresh.
module cram_dram_sched #(
  parameter int REF_INTERVAL = 120,
  parameter int CAS_CYC      = 2,
  parameter int PRE_CYC      = 2
) (
  input  logic        DotClk,
  input  logic        nRES,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [10:0] bus_row,
  input  logic [10:0] bus_col,
  input  logic [7:0]  bus_wdata,
  output logic        bus_ack,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [10:0] aux_row,
  input  logic [10:0] aux_col,
  input  logic [7:0]  aux_wdata,
  output logic        aux_ack,
  output logic [7:0]  rdata,
  output logic [10:0] RA,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nRWE,
  input  logic [7:0]  rd_in,
  output logic [7:0]  rd_out,
  output logic        rd_oe,
  output logic [1:0]  ref_owed,
  output logic        ref_overrun
);

  localparam int TW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [1:0] CAS_LAST = 2'(CAS_CYC - 1);
  localparam logic [1:0] PRE_LAST = 2'(PRE_CYC - 1);

  typedef enum logic [2:0] {IDLE, ROW, COL, PRE, RCAS, RRAS} stateT;

  stateT         state;
  logic [1:0]    cnt;
  logic [TW-1:0] refTimer;
  logic          latAux;
  logic          latWe;
  logic [10:0]   latCol;
  logic [7:0]    latWdata;
  logic          rrAux;

  logic refWrap;
  logic refTake;
  logic grantAny;
  logic grantAux;

  assign refWrap  = (refTimer == TW'(REF_INTERVAL - 1));
  assign refTake  = (state == IDLE) && (ref_owed != 2'd0);
  assign grantAny = bus_req || aux_req;
  // A lone requester wins outright; the pointer only settles a tie.
  assign grantAux = aux_req && (!bus_req || rrAux);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge DotClk or negedge nRES) begin
    if (!nRES) begin
      refTimer    <= '0;
      ref_owed    <= 2'd0;
      ref_overrun <= 1'b0;
    end else begin
      refTimer <= refWrap ? '0 : refTimer + TW'(1);
      if (refWrap && !refTake) begin
        if (ref_owed == 2'd3) ref_overrun <= 1'b1;
        else                  ref_owed    <= ref_owed + 2'd1;
      end else if (refTake && !refWrap) begin
        ref_owed <= ref_owed - 2'd1;
      end
    end
  end

  always_ff @(posedge DotClk or negedge nRES) begin
    if (!nRES) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      latAux   <= 1'b0;
      latWe    <= 1'b0;
      latCol   <= '0;
      latWdata <= '0;
      rrAux    <= 1'b0;
      bus_ack  <= 1'b0;
      aux_ack  <= 1'b0;
      rdata    <= '0;
      RA       <= '0;
      nRAS     <= 1'b1;
      nCAS     <= 1'b1;
      nRWE     <= 1'b1;
      rd_out   <= '0;
      rd_oe    <= 1'b0;
    end else begin
      bus_ack <= 1'b0;
      aux_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (refTake) begin
            state <= RCAS;
            nCAS  <= 1'b0;
            RA    <= '0;
          end else if (grantAny) begin
            state    <= ROW;
            nRAS     <= 1'b0;
            RA       <= grantAux ? aux_row   : bus_row;
            latAux   <= grantAux;
            latWe    <= grantAux ? aux_we    : bus_we;
            latCol   <= grantAux ? aux_col   : bus_col;
            latWdata <= grantAux ? aux_wdata : bus_wdata;
            rrAux    <= !grantAux;
          end
        end
        ROW: begin
          state <= COL;
          RA    <= latCol;
          nCAS  <= 1'b0;
          cnt   <= CAS_LAST;
          if (latWe) begin
            nRWE   <= 1'b0;
            rd_oe  <= 1'b1;
            rd_out <= latWdata;
          end
        end
        COL: begin
          if (cnt == 2'd0) begin
            state  <= PRE;
            cnt    <= PRE_LAST;
            nRAS   <= 1'b1;
            nCAS   <= 1'b1;
            nRWE   <= 1'b1;
            rd_oe  <= 1'b0;
            rd_out <= '0;
            RA     <= '0;
            if (!latWe) rdata <= rd_in;
            bus_ack <= !latAux;
            aux_ack <= latAux;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        PRE: begin
          if (cnt == 2'd0) state <= IDLE;
          else             cnt   <= cnt - 2'd1;
        end
        RCAS: begin
          state <= RRAS;
          nRAS  <= 1'b0;
          cnt   <= CAS_LAST;
        end
        RRAS: begin
          if (cnt == 2'd0) begin
            state <= PRE;
            cnt   <= PRE_LAST;
            nRAS  <= 1'b1;
            nCAS  <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
